// File: rtl/nanomamba_pkg.sv
// Shared definitions for the nanomamba keyword-spotting back end: default sizes,
// argmax FSM state encoding and the logit-to-confidence mapping.
package nanomamba_pkg;

    localparam int N_CLASSES_DEF = 12;
    localparam int LOGIT_W_DEF   = 8;
    localparam int CLS_W_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAPT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Signed logit to offset binary: -128 -> 0x00, 0 -> 0x80, 127 -> 0xFF.
    function automatic logic [7:0] offset_conf(input logic [7:0] v);
        return {~v[7], v[6:0]};
    endfunction

endpackage

// File: rtl/nanomamba_argmax_if.sv
// Classifier logit stream: valid/ready handshake carrying one signed logit per beat.
interface nanomamba_argmax_if
    import nanomamba_pkg::*;
#(
    parameter int LOGIT_W = LOGIT_W_DEF
);
    logic                      logit_valid;
    logic                      logit_ready;
    logic signed [LOGIT_W-1:0] logit_data;
    logic                      logit_last;

    modport master (
        output logit_valid,
        output logit_data,
        output logit_last,
        input  logit_ready
    );

    modport slave (
        input  logit_valid,
        input  logit_data,
        input  logit_last,
        output logit_ready
    );
endinterface

// File: rtl/nanomamba_argmax.sv
// Captures one frame of classifier logits, tracks the running argmax and reports
// the winning class, its offset-binary confidence and a keyword-detect flag.
module nanomamba_argmax
    import nanomamba_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int LOGIT_W   = LOGIT_W_DEF,
    parameter int CLS_W     = CLS_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    nanomamba_argmax_if.slave    lg,
    input  logic [7:0]           cfg_kw_threshold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CLS_W-1:0]     result_class,
    output logic [7:0]           result_confidence,
    output logic                 kw_detect,
    input  logic [CLS_W-1:0]     logit_rd_idx,
    output logic [LOGIT_W-1:0]   logit_rd_data
);

    localparam logic [CLS_W-1:0]          LAST_IDX  = CLS_W'(N_CLASSES - 1);
    localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

    state_t                    state_r;
    logic [CLS_W-1:0]          count_r;
    logic signed [LOGIT_W-1:0] max_r;
    logic [CLS_W-1:0]          idx_r;
    logic signed [LOGIT_W-1:0] buf_r [N_CLASSES];
    logic                      busy_r;
    logic                      ready_r;
    logic                      done_r;
    logic                      error_r;
    logic [CLS_W-1:0]          class_r;
    logic [7:0]                conf_r;
    logic                      kw_r;
    logic [7:0]                conf_s;
    logic                      accept_s;

    // Confidence uses the top byte of the running max, so wider logits scale down.
    assign conf_s   = offset_conf(max_r[LOGIT_W-1 -: 8]);
    assign accept_s = lg.logit_valid && ready_r;

    // Capture FSM: buffer writes, running argmax, result registration and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            max_r   <= LOGIT_MIN;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            class_r <= '0;
            conf_r  <= 8'h00;
            kw_r    <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_CAPT;
                        count_r <= '0;
                        max_r   <= LOGIT_MIN;
                        idx_r   <= '0;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b0;
                    end else if (accept_s) begin
                        buf_r[count_r] <= lg.logit_data;
                        count_r        <= count_r + 1'b1;
                        // Strict compare keeps the lowest index on ties.
                        if (lg.logit_data > max_r) begin
                            max_r <= lg.logit_data;
                            idx_r <= count_r;
                        end
                        if (count_r == LAST_IDX) begin
                            state_r <= ST_FINISH;
                            ready_r <= 1'b0;
                            if (!lg.logit_last) begin
                                error_r <= 1'b1;
                            end
                        end else if (lg.logit_last) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b0;
                            error_r <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    class_r <= idx_r;
                    conf_r  <= conf_s;
                    kw_r    <= (conf_s >= cfg_kw_threshold);
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Random-access readout of the stored frame; out-of-range indices read as zero.
    always_comb begin
        logit_rd_data = '0;
        if (int'(logit_rd_idx) < N_CLASSES) begin
            logit_rd_data = buf_r[logit_rd_idx];
        end else begin
            logit_rd_data = '0;
        end
    end

    assign lg.logit_ready    = ready_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;
    assign result_class      = class_r;
    assign result_confidence = conf_r;
    assign kw_detect         = kw_r;

endmodule
